// File: rtl/vending_machine_n_if.sv
// vending_machine_n_if: coin/keypad front end, dispense and change-hopper signals of vending_machine_n.
interface vending_machine_n_if #(
  parameter int SEL_W = 2,
  parameter int PRICE_W = 8
);
  logic coin_valid, coin_reject, sel_valid, cancel, restock_valid, change_ready;
  logic sold_out, vend_valid, change_valid, busy;
  logic [1:0] coin_code, change_code;
  logic [SEL_W-1:0] sel_idx, restock_idx, vend_idx, audit_idx;
  logic [PRICE_W-1:0] balance;
  logic [15:0] audit_count;
  modport master (
    output coin_valid, coin_code, sel_valid, sel_idx, cancel, restock_valid, restock_idx,
           change_ready, audit_idx,
    input  coin_reject, sold_out, vend_valid, vend_idx, change_valid, change_code, balance,
           busy, audit_count
  );
  modport slave (
    input  coin_valid, coin_code, sel_valid, sel_idx, cancel, restock_valid, restock_idx,
           change_ready, audit_idx,
    output coin_reject, sold_out, vend_valid, vend_idx, change_valid, change_code, balance,
           busy, audit_count
  );
endinterface

// File: rtl/vending_machine_n.sv
// vending_machine_n: N-item vending controller with credit cap, stock and greedy coin-by-coin change.
// Define VM_AUDIT_EN to build per-item 16-bit sales counters readable through audit_idx/audit_count.
module vending_machine_n #(
  parameter int NUM_ITEMS = 4,
  parameter int PRICE_W = 8,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES = {8'd75, 8'd50, 8'd35, 8'd20},
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5
) (
  input logic clk,
  input logic rst,
  vending_machine_n_if.slave bus
);
  localparam int SEL_W = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1;
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  state_t state;
  logic [STOCK_W-1:0] stock [NUM_ITEMS];
  logic pend_v, coin_ok, sel_ok, sel_hit, tgt_v, do_vend;
  logic [SEL_W-1:0] pend_idx, tgt_idx;
  logic [PRICE_W:0] sum;
  logic [PRICE_W-1:0] credit, remain, paid;
  logic [NUM_ITEMS-1:0] vd, rs;
  function automatic logic [PRICE_W-1:0] price(input logic [SEL_W-1:0] i);
    return PRICES[32'(i)*PRICE_W +: PRICE_W];
  endfunction
  function automatic logic [PRICE_W-1:0] coin_val(input logic [1:0] c);
    return PRICE_W'(c == 2'd3 ? 25 : c == 2'd2 ? 10 : c == 2'd1 ? 5 : 1);
  endfunction
  function automatic logic [1:0] greedy(input logic [PRICE_W-1:0] b);
    return 32'(b) >= 25 ? 2'd3 : 32'(b) >= 10 ? 2'd2 : 32'(b) >= 5 ? 2'd1 : 2'd0;
  endfunction
  // Cap check is done one bit wider so the credit can never wrap.
  always_comb begin
    sum = {1'b0, bus.balance} + {1'b0, coin_val(bus.coin_code)};
    coin_ok = state == IDLE && !bus.cancel && bus.coin_valid && sum <= (PRICE_W+1)'(MAX_CREDIT);
    credit = coin_ok ? sum[PRICE_W-1:0] : bus.balance;
    sel_ok = state == IDLE && !bus.cancel && bus.sel_valid && 32'(bus.sel_idx) < NUM_ITEMS;
    sel_hit = sel_ok && stock[bus.sel_idx] != '0;
    tgt_v = sel_hit || pend_v;
    tgt_idx = sel_hit ? bus.sel_idx : pend_idx;
    do_vend = state == VEND;
    remain = bus.balance - price(pend_idx);
    paid = bus.balance - coin_val(bus.change_code);
    vd = '0;
    rs = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      vd[i] = do_vend && pend_idx == SEL_W'(i);
      rs[i] = bus.restock_valid && bus.restock_idx == SEL_W'(i);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pend_v <= 1'b0;
      pend_idx <= '0;
      bus.coin_reject <= 1'b0;
      bus.sold_out <= 1'b0;
      bus.vend_valid <= 1'b0;
      bus.vend_idx <= '0;
      bus.change_valid <= 1'b0;
      bus.change_code <= 2'd0;
      bus.balance <= '0;
      bus.busy <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      bus.coin_reject <= bus.coin_valid && !coin_ok;
      bus.sold_out <= sel_ok && !sel_hit;
      bus.vend_valid <= do_vend;
      // Same-item vend and restock cancel out; restock alone saturates.
      for (int i = 0; i < NUM_ITEMS; i++)
        if (vd[i] != rs[i])
          stock[i] <= vd[i] ? stock[i] - STOCK_W'(1) : stock[i] == '1 ? stock[i] : stock[i] + STOCK_W'(1);
      case (state)
        IDLE: begin
          bus.balance <= credit;
          pend_v <= !bus.cancel && tgt_v;
          pend_idx <= tgt_idx;
          if (bus.cancel) begin
            state <= bus.balance != '0 ? CHANGE : IDLE;
            bus.busy <= bus.balance != '0;
          end else if (tgt_v && credit >= price(tgt_idx)) begin
            state <= VEND;
            bus.busy <= 1'b1;
          end
        end
        VEND: begin
          bus.vend_idx <= pend_idx;
          bus.balance <= remain;
          pend_v <= 1'b0;
          state <= remain != '0 ? CHANGE : IDLE;
          bus.busy <= remain != '0;
        end
        CHANGE:
          if (!bus.change_valid) begin
            bus.change_valid <= 1'b1;
            bus.change_code <= greedy(bus.balance);
          end else if (bus.change_ready) begin
            bus.balance <= paid;
            bus.change_valid <= paid != '0;
            bus.change_code <= greedy(paid);
            if (paid == '0) begin
              state <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
`ifdef VM_AUDIT_EN
  logic [15:0] sales [NUM_ITEMS];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) sales[i] <= '0;
      bus.audit_count <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++)
        if (vd[i] && sales[i] != '1) sales[i] <= sales[i] + 16'd1;
      bus.audit_count <= sales[bus.audit_idx];
    end
`else
  logic unused_audit;
  assign unused_audit = ^bus.audit_idx;
  assign bus.audit_count = '0;
`endif
endmodule

// File: tb/tb_vending_machine_n.sv
// tb_vending_machine_n: scoreboard bench; directed and random transactions checked against a
// transaction-level model of credit, pending selection, stock and greedy change.
`timescale 1ns/1ps
module tb_vending_machine_n;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_pass = 0, n_fail = 0, rdy_mode = 1;
  int credit = 0, pend = -1, prev_code = 0;
  int stock[4], sales[4];
  int prices[4] = '{20, 35, 50, 75};
  int cents[4] = '{1, 5, 10, 25};
  int q_rej[$], q_sold[$], q_vidx[$], q_vcyc[$], q_chg[$];
  bit stall_prev = 0;
  vending_machine_n_if #(.SEL_W(2), .PRICE_W(8)) vif();
  vending_machine_n dut (.clk(clk), .rst(rst), .bus(vif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int audit_exp(input int i);
`ifdef VM_AUDIT_EN
    return sales[i];
`else
    return 0;
`endif
  endfunction

  function automatic void refund();
    while (credit > 0) begin
      int c = credit >= 25 ? 3 : credit >= 10 ? 2 : credit >= 5 ? 1 : 0;
      q_chg.push_back(c);
      credit -= cents[c];
    end
  endfunction

  function automatic void model(input int k, input bit cv, input int cc, input bit sv, input int si,
                                input bit cn, input bit rv, input int ri);
    if (cn) begin
      if (cv) q_rej.push_back(k + 1);
      pend = -1;
      refund();
    end else begin
      if (cv) begin
        if (credit + cents[cc] > 100) q_rej.push_back(k + 1);
        else credit += cents[cc];
      end
      if (sv) begin
        if (stock[si] == 0) q_sold.push_back(k + 1);
        else pend = si;
      end
    end
    if (rv && stock[ri] < 15) stock[ri]++;
    if (!cn && pend >= 0 && credit >= prices[pend]) begin
      q_vidx.push_back(pend);
      q_vcyc.push_back(k + 2);
      stock[pend]--;
      sales[pend]++;
      credit -= prices[pend];
      pend = -1;
      refund();
    end
  endfunction

  function automatic void reset_model();
    credit = 0;
    pend = -1;
    for (int i = 0; i < 4; i++) begin
      stock[i] = 5;
      sales[i] = 0;
    end
    q_rej.delete(); q_sold.delete(); q_vidx.delete(); q_vcyc.delete(); q_chg.delete();
  endfunction

  task automatic idle_inputs();
    vif.coin_valid = 0; vif.coin_code = 0; vif.sel_valid = 0; vif.sel_idx = 0;
    vif.cancel = 0; vif.restock_valid = 0; vif.restock_idx = 0;
  endtask

  task automatic tx(input bit cv, input int cc, input bit sv, input int si, input bit cn, input bit rv, input int ri);
    @(negedge clk);
    vif.coin_valid = cv; vif.coin_code = 2'(cc); vif.sel_valid = sv; vif.sel_idx = 2'(si);
    vif.cancel = cn; vif.restock_valid = rv; vif.restock_idx = 2'(ri);
    model(cyc, cv, cc, sv, si, cn, rv, ri);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic drain();
    int t = 0;
    while (q_rej.size() + q_sold.size() + q_vidx.size() + q_chg.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t == 300) begin
      chk("drain_timeout", q_rej.size() + q_sold.size() + q_vidx.size() + q_chg.size(), 0);
      q_rej.delete(); q_sold.delete(); q_vidx.delete(); q_vcyc.delete(); q_chg.delete();
    end
    repeat (2) @(negedge clk);
    chk("balance", int'(vif.balance), credit);
    chk("busy_idle", int'(vif.busy), 0);
  endtask

  task automatic op(input bit cv, input int cc, input bit sv, input int si, input bit cn, input bit rv, input int ri);
    tx(cv, cc, sv, si, cn, rv, ri);
    drain();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_balance"}, int'(vif.balance), 0);
    chk({tag, "_busy"}, int'(vif.busy), 0);
    chk({tag, "_vend_valid"}, int'(vif.vend_valid), 0);
    chk({tag, "_vend_idx"}, int'(vif.vend_idx), 0);
    chk({tag, "_change_valid"}, int'(vif.change_valid), 0);
    chk({tag, "_change_code"}, int'(vif.change_code), 0);
    chk({tag, "_coin_reject"}, int'(vif.coin_reject), 0);
    chk({tag, "_sold_out"}, int'(vif.sold_out), 0);
    chk({tag, "_audit_count"}, int'(vif.audit_count), 0);
  endtask

  task automatic audit_check(input int i);
    @(negedge clk);
    vif.audit_idx = 2'(i);
    @(negedge clk);
    chk("audit_count", int'(vif.audit_count), audit_exp(i));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    vif.change_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : $urandom_range(3) != 0;
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (rst) stall_prev = 0;
    else begin
      if (vif.coin_reject) begin
        if (q_rej.size() == 0) chk("coin_reject_spurious", int'(vif.coin_reject), 0);
        else chk("coin_reject_cycle", cyc, q_rej.pop_front());
      end
      if (vif.sold_out) begin
        if (q_sold.size() == 0) chk("sold_out_spurious", int'(vif.sold_out), 0);
        else chk("sold_out_cycle", cyc, q_sold.pop_front());
      end
      if (vif.vend_valid) begin
        if (q_vidx.size() == 0) chk("vend_spurious", int'(vif.vend_valid), 0);
        else begin
          chk("vend_idx", int'(vif.vend_idx), q_vidx.pop_front());
          chk("vend_cycle", cyc, q_vcyc.pop_front());
        end
      end
      if (stall_prev) begin
        chk("stall_valid", int'(vif.change_valid), 1);
        chk("stall_code", int'(vif.change_code), prev_code);
      end
      if (vif.change_valid && vif.change_ready) begin
        if (q_chg.size() == 0) chk("change_spurious", int'(vif.change_valid), 0);
        else chk("change_code", int'(vif.change_code), q_chg.pop_front());
      end
      stall_prev = vif.change_valid && !vif.change_ready;
      prev_code = int'(vif.change_code);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    vif.audit_idx = 0;
    vif.change_ready = 0;
    reset_model();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 0;
    rdy_mode = 1;
    op(0, 0, 1, 1, 0, 0, 0);
    op(1, 3, 0, 0, 0, 0, 0);
    op(1, 3, 0, 0, 0, 0, 0);
    op(1, 2, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 1, 0, 0);
    for (int r = 0; r < 5; r++) begin
      op(1, 3, 0, 0, 0, 0, 0);
      op(0, 0, 1, 0, 0, 0, 0);
    end
    op(1, 3, 0, 0, 0, 0, 0);
    op(0, 0, 1, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 0);
    op(0, 0, 1, 0, 0, 0, 0);
    rdy_mode = 0;
    for (int r = 0; r < 5; r++) op(1, 3, 0, 0, 0, 0, 0);
    op(1, 3, 0, 0, 1, 0, 0);
    op(1, 3, 0, 0, 0, 0, 0);
    op(1, 2, 0, 0, 0, 0, 0);
    rdy_mode = 2;
    tx(0, 0, 0, 0, 1, 0, 0);
    repeat (6) @(negedge clk);
    @(negedge clk);
    vif.coin_valid = 1;
    vif.coin_code = 2'd1;
    q_rej.push_back(cyc + 1);
    @(negedge clk);
    vif.coin_valid = 0;
    repeat (2) @(negedge clk);
    chk("stall_hold_valid", int'(vif.change_valid), 1);
    chk("stall_hold_code", int'(vif.change_code), 3);
    chk("stall_hold_balance", int'(vif.balance), 35);
    chk("stall_hold_busy", int'(vif.busy), 1);
    #2 rst = 1;
    #1 reset_checks("midreset");
    @(negedge clk);
    #2 rst = 0;
    reset_model();
    rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      op(1, 3, 0, 0, 0, 0, 0);
      op(1, 3, 0, 0, 0, 0, 0);
      op(0, 0, 1, 2, 0, 0, 0);
    end
    audit_check(2);
    rdy_mode = 0;
    for (int r = 0; r < 200; r++) begin
      op($urandom_range(3) != 0, $urandom_range(3), $urandom_range(2) == 0, $urandom_range(3),
         $urandom_range(9) == 0, $urandom_range(7) == 0, $urandom_range(3));
      if (r % 25 == 0) audit_check($urandom_range(3));
    end
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
